// File: rtl/seq_resp_pkg.sv
// Shared definitions for the sequence responder: FSM state encoding and
// sizing constants used by the top level, the pending-response pipe and the
// bus interface.
package seq_resp_pkg;

    // Controller states: IDLE (not accepting), ACTIVE (accepting requests),
    // DRAIN (not accepting, but responses still in flight).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Deepest supported response latency.
    localparam int DELAY_MAX = 8;

    // Default response-counter width.
    localparam int CNT_W_DEF = 16;

endpackage : seq_resp_pkg

// File: rtl/seq_resp_if.sv
// Request/response bus of the sequence responder. The master drives the
// enable and the two request qualifiers; the slave (the responder) returns
// the response strobe, its complement, the busy flag and the response count.
interface seq_resp_if
    import seq_resp_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             en;
    logic             c;
    logic             d;
    logic             a;
    logic             b;
    logic             busy;
    logic [CNT_W-1:0] resp_cnt;

    modport master (
        output en,
        output c,
        output d,
        input  a,
        input  b,
        input  busy,
        input  resp_cnt
    );

    modport slave (
        input  en,
        input  c,
        input  d,
        output a,
        output b,
        output busy,
        output resp_cnt
    );

endinterface : seq_resp_if

// File: rtl/seq_resp_pipe.sv
// DELAY-deep shift register of pending responses. Bit 0 loads the incoming
// trigger; the value about to enter bit DELAY-1 is exported as tail_next so
// the caller can register its outputs in step with the last stage. Cleared
// asynchronously by the active-low reset.
module seq_resp_pipe
    import seq_resp_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [DELAY-1:0] q,
    output logic             tail_next,
    output logic             empty
);

    logic [DELAY-1:0] nxt;

    // Next contents: everything moves one place towards the tail, din enters bit 0.
    if (DELAY == 1) begin : g_single
        assign nxt = din;
    end else begin : g_multi
        assign nxt = {q[DELAY-2:0], din};
    end

    assign tail_next = nxt[DELAY-1];
    assign empty     = (q == '0);

    // Shift on every clock; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule : seq_resp_pipe

// File: rtl/seq_responder.sv
// Sequence responder top level. A request (en && c && d at a rising clock
// edge) produces a one-cycle response strobe a (with b = ~a) that is sampled
// high DELAY edges later. Back-to-back requests give back-to-back responses.
// A small IDLE/ACTIVE/DRAIN controller reports busy, and a saturating counter
// tallies delivered responses.
// Optional build macro: SEQ_RESP_ASSERT_EN compiles in embedded latency and
// a/b-complement assertions; without it the module contains no checks.
module seq_responder
    import seq_resp_pkg::*;
#(
    parameter int DELAY = 1,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    seq_resp_if.slave bus
);

    logic             trigger;
    logic [DELAY-1:0] pipe_q;
    logic             pipe_empty;
    logic             tail_next;
    logic             a_q;
    logic             b_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           state;

    // Qualifiers are ignored whenever en is low, so DRAIN accepts nothing new.
    assign trigger = bus.en & bus.c & bus.d;

    seq_resp_pipe #(
        .DELAY (DELAY)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .din       (trigger),
        .q         (pipe_q),
        .tail_next (tail_next),
        .empty     (pipe_empty)
    );

    // Response strobe and its complement, loaded alongside the last pipe stage
    // so a trigger appears on a exactly DELAY edges after it is sampled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= 1'b0;
            b_q <= 1'b1;
        end else begin
            a_q <= tail_next;
            b_q <= ~tail_next;
        end
    end

    // Controller: busy is registered together with the state it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state  <= ACTIVE;
                        busy_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!bus.en) begin
                        if (pipe_empty) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.en) begin
                        state  <= ACTIVE;
                    end else if (pipe_empty) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Delivered-response counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (a_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.busy     = busy_q;
    assign bus.resp_cnt = cnt_q;

`ifdef SEQ_RESP_ASSERT_EN
    // Every accepted request must show up as a response DELAY edges later.
    property p_latency;
        @(posedge clk) disable iff (!rst)
            trigger |-> ##DELAY (bus.a && !bus.b);
    endproperty

    a_latency : assert property (p_latency)
        else $error("seq_responder: response missing DELAY cycles after trigger");

    // The strobe and its complement must never agree.
    a_complement : assert property (@(posedge clk) disable iff (!rst) (bus.a != bus.b))
        else $error("seq_responder: a and b are equal");
`else
    // Plain build: no embedded checks.
`endif

endmodule : seq_responder

// File: tb/tb_seq_responder.sv
// Bench for seq_responder: three instances (DELAY=1/CNT_W=16, DELAY=3/CNT_W=16,
// DELAY=2/CNT_W=4) share one stimulus stream. An event-level reference model
// records, for every accepted request, the clock edge at which its response
// must be visible, and derives busy and the saturating count from that.
module tb_seq_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic c   = 1'b0;
    logic d   = 1'b0;

    always #5 clk = ~clk;

    seq_resp_if #(.CNT_W(16)) bus0 ();
    seq_resp_if #(.CNT_W(16)) bus1 ();
    seq_resp_if #(.CNT_W(4))  bus2 ();

    assign bus0.en = en;
    assign bus0.c  = c;
    assign bus0.d  = d;
    assign bus1.en = en;
    assign bus1.c  = c;
    assign bus1.d  = d;
    assign bus2.en = en;
    assign bus2.c  = c;
    assign bus2.d  = d;

    seq_responder #(.DELAY(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_responder #(.DELAY(3), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_responder #(.DELAY(2), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int NE = 8192;
    bit vis [3][NE];               // vis[i][e]: response visible just after edge e
    int dly  [3] = '{1, 3, 2};
    int cmax [3] = '{65535, 65535, 15};
    int cnt_m [3];
    bit busy_m [3];
    int edge_n = 16;

    // At each rising edge: account responses seen in the cycle that just ended,
    // update busy from en and outstanding work, and schedule new requests.
    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt_m[i]  = 0;
            busy_m[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    bit pending;
                    pending = 1'b0;
                    for (int m = edge_n - 1; m <= edge_n + dly[i] - 2; m++)
                        pending = pending | vis[i][m];
                    if (vis[i][edge_n-1] && cnt_m[i] < cmax[i])
                        cnt_m[i]++;
                    busy_m[i] = en ? 1'b1 : (busy_m[i] && pending);
                    if (en && c && d)
                        vis[i][edge_n + dly[i] - 1] = 1'b1;
                end
            end
        end
    end

    task automatic check_one(input int i, input logic a_g, input logic b_g,
                             input logic busy_g, input logic [31:0] cnt_g);
        chk($sformatf("a%0d", i),    {31'd0, a_g},    {31'd0, vis[i][edge_n]});
        chk($sformatf("b%0d", i),    {31'd0, b_g},    {31'd0, !vis[i][edge_n]});
        chk($sformatf("busy%0d", i), {31'd0, busy_g}, {31'd0, busy_m[i]});
        chk($sformatf("cnt%0d", i),  cnt_g,           cnt_m[i]);
    endtask

    // Sample all outputs mid-cycle; reset wipes everything in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    for (int m = edge_n - 2; m <= edge_n + 12; m++)
                        vis[i][m] = 1'b0;
                    cnt_m[i]  = 0;
                    busy_m[i] = 1'b0;
                end
            end
            check_one(0, bus0.a, bus0.b, bus0.busy, 32'(bus0.resp_cnt));
            check_one(1, bus1.a, bus1.b, bus1.busy, 32'(bus1.resp_cnt));
            check_one(2, bus2.a, bus2.b, bus2.busy, 32'(bus2.resp_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic e, input logic cc, input logic dd);
        en = e;
        c  = cc;
        d  = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // single request, sampled at the first edge after reset release
        cyc(1, 1, 1);
        chk("single_a0", {31'd0, bus0.a}, 32'd1);
        repeat (6) cyc(1, 0, 0);
        chk("single_cnt0", bus0.resp_cnt, 1);
        chk("single_cnt1", bus1.resp_cnt, 1);
        chk("single_cnt2", 32'(bus2.resp_cnt), 1);

        // qualifier low, then enable low: no responses
        repeat (4) cyc(1, 0, 1);
        repeat (4) cyc(0, 1, 1);
        chk("noreq_cnt1", bus1.resp_cnt, 1);

        // three back-to-back requests
        repeat (3) cyc(1, 1, 1);
        repeat (6) cyc(1, 0, 0);
        chk("b2b_cnt1", bus1.resp_cnt, 4);

        // request followed by enable drop: drain then idle
        cyc(1, 1, 1);
        cyc(0, 1, 1);
        chk("drain_busy1", {31'd0, bus1.busy}, 32'd1);
        chk("drain_state1", 32'(dut1.state), 32'd2);
        repeat (6) cyc(0, 0, 0);
        chk("drain_idle1", {31'd0, bus1.busy}, 32'd0);
        chk("drain_cnt1", bus1.resp_cnt, 5);

        // request, then reset one cycle later: response discarded
        cyc(1, 1, 1);
        en = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) cyc(0, 0, 0);
        chk("rst_cnt2", 32'(bus2.resp_cnt), 0);
        chk("rst_cnt0", bus0.resp_cnt, 0);

        // twenty requests: narrow counter saturates
        repeat (20) cyc(1, 1, 1);
        repeat (6) cyc(1, 0, 0);
        chk("sat_cnt2", 32'(bus2.resp_cnt), 15);
        chk("sat_cnt1", bus1.resp_cnt, 20);

        // randomized traffic with occasional resets
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                en  = 1'b0;
                rst = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1 rst = 1'b1;
            end else begin
                cyc(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0);
            end
        end
        repeat (10) cyc(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_responder
